// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM state
// encoding, master identifiers and the request record routed to memory.
package mem_bus_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int LEN_W  = 5;

   // One-hot channel FSM states
   localparam logic [2:0] ST_IDLE = 3'b001;
   localparam logic [2:0] ST_REQ  = 3'b010;
   localparam logic [2:0] ST_DATA = 3'b100;

   // Master identifiers, also the encoding of rd_owner / wr_owner
   localparam logic M_CPU = 1'b0;
   localparam logic M_DMA = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } req_t;

   // Winner among pending requests: the favoured master on a tie,
   // otherwise whichever single master is asking.
   function automatic logic pick_owner(input logic [1:0] valid, input logic prio);
      if (valid == 2'b11) begin
         return prio;
      end
      return valid[1];
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_channel.sv
// One arbitration channel: grant FSM, round-robin priority pointer and
// burst beat counter with length checking. Data routing lives in the top.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no grant; any pending request is latched as owner
//   REQ     | owner's request presented to memory, waiting for handshake
//   DATA    | burst beats flowing, ends on an accepted beat with last=1
module arb_channel
   import mem_bus_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   input  logic             req_hs,
   input  logic [LEN_W-1:0] req_len,
   input  logic             beat_acc,
   input  logic             beat_last,
   output logic [2:0]       state,
   output logic             owner,
   output logic             err
);

   logic             prio;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] beat_cnt;
   logic [2:0]       state_nxt;
   logic             cnt_at_len;

   assign cnt_at_len = (beat_cnt == len_q);

   // Next-state decode; a request is never granted in the cycle a burst ends
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (|req_valid)            state_nxt = ST_REQ;
         ST_REQ:  if (req_hs)                state_nxt = ST_DATA;
         ST_DATA: if (beat_acc && beat_last) state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   // State, grant owner and priority pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         owner <= M_CPU;
         prio  <= M_CPU;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && |req_valid) begin
            owner <= pick_owner(req_valid, prio);
         end
         if (state == ST_DATA && beat_acc && beat_last) begin
            prio <= ~owner;
         end
      end
   end

   // Granted length, beat counter and sticky length-mismatch flag
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q    <= '0;
         beat_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == ST_REQ && req_hs) begin
            len_q    <= req_len;
            beat_cnt <= '0;
         end
         if (state == ST_DATA && beat_acc) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            // last early/late both flag; termination still follows last only
            if (beat_last != cnt_at_len) begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU = M0, DMA = M1) memory bus arbiter. Read and write
// channels are granted independently by separate arb_channel instances;
// this level only steers request fields and data beats to/from the owner.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   // master 0 read
   input  logic [31:0]           m0_rd_req_addr,
   input  logic [4:0]            m0_rd_req_len,
   input  logic                  m0_rd_req_valid,
   output logic                  m0_rd_req_ready,
   output logic [DATA_WIDTH-1:0] m0_rd_rdata,
   output logic                  m0_rd_last,
   output logic                  m0_rd_valid,
   input  logic                  m0_rd_ready,
   // master 1 read
   input  logic [31:0]           m1_rd_req_addr,
   input  logic [4:0]            m1_rd_req_len,
   input  logic                  m1_rd_req_valid,
   output logic                  m1_rd_req_ready,
   output logic [DATA_WIDTH-1:0] m1_rd_rdata,
   output logic                  m1_rd_last,
   output logic                  m1_rd_valid,
   input  logic                  m1_rd_ready,
   // master 0 write
   input  logic [31:0]           m0_wr_req_addr,
   input  logic [4:0]            m0_wr_req_len,
   input  logic                  m0_wr_req_valid,
   output logic                  m0_wr_req_ready,
   input  logic [DATA_WIDTH-1:0] m0_wr_data,
   input  logic                  m0_wr_valid,
   input  logic                  m0_wr_last,
   output logic                  m0_wr_ready,
   // master 1 write
   input  logic [31:0]           m1_wr_req_addr,
   input  logic [4:0]            m1_wr_req_len,
   input  logic                  m1_wr_req_valid,
   output logic                  m1_wr_req_ready,
   input  logic [DATA_WIDTH-1:0] m1_wr_data,
   input  logic                  m1_wr_valid,
   input  logic                  m1_wr_last,
   output logic                  m1_wr_ready,
   // memory read side
   output logic [31:0]           mem_rd_req_addr,
   output logic [4:0]            mem_rd_req_len,
   output logic                  mem_rd_req_valid,
   input  logic                  mem_rd_req_ready,
   input  logic [DATA_WIDTH-1:0] mem_rd_rdata,
   input  logic                  mem_rd_last,
   input  logic                  mem_rd_valid,
   output logic                  mem_rd_ready,
   // memory write side
   output logic [31:0]           mem_wr_req_addr,
   output logic [4:0]            mem_wr_req_len,
   output logic                  mem_wr_req_valid,
   input  logic                  mem_wr_req_ready,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  mem_wr_valid,
   output logic                  mem_wr_last,
   input  logic                  mem_wr_ready,
   // status
   output logic                  rd_owner,
   output logic                  wr_owner,
   output logic                  beat_err
);

   logic [2:0] rd_state;
   logic [2:0] wr_state;
   logic       rd_in_req, rd_in_data, wr_in_req, wr_in_data;
   logic       rd_hs, rd_acc, wr_hs, wr_acc;
   logic       rd_err, wr_err;
   req_t       rd_req0, rd_req1, rd_req_sel;
   req_t       wr_req0, wr_req1, wr_req_sel;

   assign rd_in_req  = (rd_state == ST_REQ);
   assign rd_in_data = (rd_state == ST_DATA);
   assign wr_in_req  = (wr_state == ST_REQ);
   assign wr_in_data = (wr_state == ST_DATA);

   arb_channel u_rd_chan (
      .clk       (clk),
      .rst       (rst),
      .req_valid ({m1_rd_req_valid, m0_rd_req_valid}),
      .req_hs    (rd_hs),
      .req_len   (mem_rd_req_len),
      .beat_acc  (rd_acc),
      .beat_last (mem_rd_last),
      .state     (rd_state),
      .owner     (rd_owner),
      .err       (rd_err)
   );

   arb_channel u_wr_chan (
      .clk       (clk),
      .rst       (rst),
      .req_valid ({m1_wr_req_valid, m0_wr_req_valid}),
      .req_hs    (wr_hs),
      .req_len   (mem_wr_req_len),
      .beat_acc  (wr_acc),
      .beat_last (mem_wr_last),
      .state     (wr_state),
      .owner     (wr_owner),
      .err       (wr_err)
   );

   assign beat_err = rd_err | wr_err;

   // Read request steering; valid is held for the whole REQ phase so a
   // withdrawn request cannot drop the grant mid-handshake
   always_comb begin
      rd_req0          = '{addr: m0_rd_req_addr, len: m0_rd_req_len};
      rd_req1          = '{addr: m1_rd_req_addr, len: m1_rd_req_len};
      rd_req_sel       = (rd_owner == M_DMA) ? rd_req1 : rd_req0;
      mem_rd_req_addr  = rd_req_sel.addr;
      mem_rd_req_len   = rd_req_sel.len;
      mem_rd_req_valid = rd_in_req;
      m0_rd_req_ready  = rd_in_req && (rd_owner == M_CPU) && mem_rd_req_ready;
      m1_rd_req_ready  = rd_in_req && (rd_owner == M_DMA) && mem_rd_req_ready;
      rd_hs            = rd_in_req && mem_rd_req_ready;
   end

   // Read data routing; memory beats are dropped whenever no burst is active
   always_comb begin
      mem_rd_ready = rd_in_data && ((rd_owner == M_DMA) ? m1_rd_ready : m0_rd_ready);
      m0_rd_rdata  = mem_rd_rdata;
      m1_rd_rdata  = mem_rd_rdata;
      m0_rd_valid  = rd_in_data && (rd_owner == M_CPU) && mem_rd_valid;
      m1_rd_valid  = rd_in_data && (rd_owner == M_DMA) && mem_rd_valid;
      m0_rd_last   = rd_in_data && (rd_owner == M_CPU) && mem_rd_last;
      m1_rd_last   = rd_in_data && (rd_owner == M_DMA) && mem_rd_last;
      rd_acc       = mem_rd_valid && mem_rd_ready;
   end

   // Write request steering
   always_comb begin
      wr_req0          = '{addr: m0_wr_req_addr, len: m0_wr_req_len};
      wr_req1          = '{addr: m1_wr_req_addr, len: m1_wr_req_len};
      wr_req_sel       = (wr_owner == M_DMA) ? wr_req1 : wr_req0;
      mem_wr_req_addr  = wr_req_sel.addr;
      mem_wr_req_len   = wr_req_sel.len;
      mem_wr_req_valid = wr_in_req;
      m0_wr_req_ready  = wr_in_req && (wr_owner == M_CPU) && mem_wr_req_ready;
      m1_wr_req_ready  = wr_in_req && (wr_owner == M_DMA) && mem_wr_req_ready;
      wr_hs            = wr_in_req && mem_wr_req_ready;
   end

   // Write data routing from the owner to memory
   always_comb begin
      mem_wr_data  = (wr_owner == M_DMA) ? m1_wr_data : m0_wr_data;
      mem_wr_valid = wr_in_data && ((wr_owner == M_DMA) ? m1_wr_valid : m0_wr_valid);
      mem_wr_last  = wr_in_data && ((wr_owner == M_DMA) ? m1_wr_last : m0_wr_last);
      m0_wr_ready  = wr_in_data && (wr_owner == M_CPU) && mem_wr_ready;
      m1_wr_ready  = wr_in_data && (wr_owner == M_DMA) && mem_wr_ready;
      wr_acc       = mem_wr_valid && mem_wr_ready;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed read table, hand-written write and
// reset sequences, then randomized traffic against a grant-order model.
module tb_mem_bus_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   m0_rd_req_addr, m1_rd_req_addr, m0_wr_req_addr, m1_wr_req_addr;
   logic [4:0]    m0_rd_req_len, m1_rd_req_len, m0_wr_req_len, m1_wr_req_len;
   logic          m0_rd_req_valid, m1_rd_req_valid, m0_wr_req_valid, m1_wr_req_valid;
   logic          m0_rd_req_ready, m1_rd_req_ready, m0_wr_req_ready, m1_wr_req_ready;
   logic [DW-1:0] m0_rd_rdata, m1_rd_rdata;
   logic          m0_rd_last, m1_rd_last, m0_rd_valid, m1_rd_valid;
   logic          m0_rd_ready, m1_rd_ready;
   logic [DW-1:0] m0_wr_data, m1_wr_data;
   logic          m0_wr_valid, m1_wr_valid, m0_wr_last, m1_wr_last;
   logic          m0_wr_ready, m1_wr_ready;
   logic [31:0]   mem_rd_req_addr, mem_wr_req_addr;
   logic [4:0]    mem_rd_req_len, mem_wr_req_len;
   logic          mem_rd_req_valid, mem_rd_req_ready, mem_wr_req_valid, mem_wr_req_ready;
   logic [DW-1:0] mem_rd_rdata, mem_wr_data;
   logic          mem_rd_last, mem_rd_valid, mem_rd_ready;
   logic          mem_wr_valid, mem_wr_last, mem_wr_ready;
   logic          rd_owner, wr_owner, beat_err;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_rd_req_addr(m0_rd_req_addr), .m0_rd_req_len(m0_rd_req_len),
      .m0_rd_req_valid(m0_rd_req_valid), .m0_rd_req_ready(m0_rd_req_ready),
      .m0_rd_rdata(m0_rd_rdata), .m0_rd_last(m0_rd_last), .m0_rd_valid(m0_rd_valid),
      .m0_rd_ready(m0_rd_ready),
      .m1_rd_req_addr(m1_rd_req_addr), .m1_rd_req_len(m1_rd_req_len),
      .m1_rd_req_valid(m1_rd_req_valid), .m1_rd_req_ready(m1_rd_req_ready),
      .m1_rd_rdata(m1_rd_rdata), .m1_rd_last(m1_rd_last), .m1_rd_valid(m1_rd_valid),
      .m1_rd_ready(m1_rd_ready),
      .m0_wr_req_addr(m0_wr_req_addr), .m0_wr_req_len(m0_wr_req_len),
      .m0_wr_req_valid(m0_wr_req_valid), .m0_wr_req_ready(m0_wr_req_ready),
      .m0_wr_data(m0_wr_data), .m0_wr_valid(m0_wr_valid), .m0_wr_last(m0_wr_last),
      .m0_wr_ready(m0_wr_ready),
      .m1_wr_req_addr(m1_wr_req_addr), .m1_wr_req_len(m1_wr_req_len),
      .m1_wr_req_valid(m1_wr_req_valid), .m1_wr_req_ready(m1_wr_req_ready),
      .m1_wr_data(m1_wr_data), .m1_wr_valid(m1_wr_valid), .m1_wr_last(m1_wr_last),
      .m1_wr_ready(m1_wr_ready),
      .mem_rd_req_addr(mem_rd_req_addr), .mem_rd_req_len(mem_rd_req_len),
      .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
      .mem_rd_rdata(mem_rd_rdata), .mem_rd_last(mem_rd_last), .mem_rd_valid(mem_rd_valid),
      .mem_rd_ready(mem_rd_ready),
      .mem_wr_req_addr(mem_wr_req_addr), .mem_wr_req_len(mem_wr_req_len),
      .mem_wr_req_valid(mem_wr_req_valid), .mem_wr_req_ready(mem_wr_req_ready),
      .mem_wr_data(mem_wr_data), .mem_wr_valid(mem_wr_valid), .mem_wr_last(mem_wr_last),
      .mem_wr_ready(mem_wr_ready),
      .rd_owner(rd_owner), .wr_owner(wr_owner), .beat_err(beat_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic rd_req_ready_of(input logic who);
      return who ? m1_rd_req_ready : m0_rd_req_ready;
   endfunction
   function automatic logic rd_valid_of(input logic who);
      return who ? m1_rd_valid : m0_rd_valid;
   endfunction
   function automatic logic rd_last_of(input logic who);
      return who ? m1_rd_last : m0_rd_last;
   endfunction
   function automatic logic [DW-1:0] rd_rdata_of(input logic who);
      return who ? m1_rd_rdata : m0_rd_rdata;
   endfunction
   function automatic logic wr_req_ready_of(input logic who);
      return who ? m1_wr_req_ready : m0_wr_req_ready;
   endfunction
   function automatic logic wr_ready_of(input logic who);
      return who ? m1_wr_ready : m0_wr_ready;
   endfunction
   function automatic logic [11:0] hs_outputs();
      return {m0_rd_req_ready, m1_rd_req_ready, m0_rd_valid, m1_rd_valid,
              m0_wr_req_ready, m1_wr_req_ready, m0_wr_ready, m1_wr_ready,
              mem_rd_req_valid, mem_wr_req_valid, mem_rd_ready, mem_wr_valid};
   endfunction

   task automatic set_rd_req(input logic who, input logic v, input logic [31:0] a, input logic [4:0] l);
      if (who) begin m1_rd_req_valid = v; m1_rd_req_addr = a; m1_rd_req_len = l; end
      else     begin m0_rd_req_valid = v; m0_rd_req_addr = a; m0_rd_req_len = l; end
   endtask
   task automatic set_wr_req(input logic who, input logic v, input logic [31:0] a, input logic [4:0] l);
      if (who) begin m1_wr_req_valid = v; m1_wr_req_addr = a; m1_wr_req_len = l; end
      else     begin m0_wr_req_valid = v; m0_wr_req_addr = a; m0_wr_req_len = l; end
   endtask
   task automatic set_wr_beat(input logic who, input logic v, input logic [DW-1:0] d, input logic l);
      if (who) begin m1_wr_valid = v; m1_wr_data = d; m1_wr_last = l; end
      else     begin m0_wr_valid = v; m0_wr_data = d; m0_wr_last = l; end
   endtask

   task automatic clear_inputs();
      set_rd_req(1'b0, 1'b0, 32'h0, 5'd0);
      set_rd_req(1'b1, 1'b0, 32'h0, 5'd0);
      set_wr_req(1'b0, 1'b0, 32'h0, 5'd0);
      set_wr_req(1'b1, 1'b0, 32'h0, 5'd0);
      set_wr_beat(1'b0, 1'b0, '0, 1'b0);
      set_wr_beat(1'b1, 1'b0, '0, 1'b0);
      m0_rd_ready = 0; m1_rd_ready = 0;
      mem_rd_req_ready = 0; mem_rd_rdata = '0; mem_rd_last = 0; mem_rd_valid = 0;
      mem_wr_req_ready = 0; mem_wr_ready = 0;
   endtask

   // Reset for one cycle, then confirm the quiet post-reset state
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_handshakes", 32'(hs_outputs()), 32'd0);
      chk("rst_rd_owner", 32'(rd_owner), 32'd0);
      chk("rst_wr_owner", 32'(wr_owner), 32'd0);
      chk("rst_beat_err", 32'(beat_err), 32'd0);
   endtask

   // Serve one read grant: expect it for `who`, then return nb beats with
   // last on the final one. gap = idle negedges before the grant showed.
   task automatic rd_serve(input logic who, input logic [31:0] addr, input logic [4:0] len,
                           input int nb, input logic rnd, output int gap);
      int   b;
      int   guard;
      logic rdy;
      gap = 0;
      @(negedge clk);
      mem_rd_valid = 0; mem_rd_last = 0; m0_rd_ready = 0; m1_rd_ready = 0;
      mem_rd_req_ready = 1;
      #1;
      while (!mem_rd_req_valid && gap < 20) begin
         @(negedge clk); #1; gap++;
      end
      chk("rd_grant_seen", 32'(gap < 20), 32'd1);
      chk("rd_owner", 32'(rd_owner), 32'(who));
      chk("rd_req_addr", mem_rd_req_addr, addr);
      chk("rd_req_len", 32'(mem_rd_req_len), 32'(len));
      chk("rd_req_ready_own", 32'(rd_req_ready_of(who)), 32'd1);
      chk("rd_req_ready_other", 32'(rd_req_ready_of(!who)), 32'd0);
      @(posedge clk); #1;
      set_rd_req(who, 1'b0, addr, len);
      mem_rd_req_ready = 0;
      b = 0; guard = 0;
      while (b < nb && guard < 300) begin
         @(negedge clk);
         mem_rd_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_rd_rdata = addr + 32'(b);
         mem_rd_last  = (b == nb - 1);
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (who) m1_rd_ready = rdy; else m0_rd_ready = rdy;
         #1;
         chk("rd_valid_own", 32'(rd_valid_of(who)), 32'(mem_rd_valid));
         chk("rd_valid_other", 32'(rd_valid_of(!who)), 32'd0);
         chk("mem_rd_ready", 32'(mem_rd_ready), 32'(rdy));
         if (mem_rd_valid) begin
            chk("rd_rdata", rd_rdata_of(who), addr + 32'(b));
            chk("rd_last", 32'(rd_last_of(who)), 32'(b == nb - 1));
         end
         if (mem_rd_valid && rdy) b++;
         guard++;
      end
      chk("rd_beats", 32'(b), 32'(nb));
   endtask

   // Serve one write grant of len+1 beats; tog alternates mem_wr_ready
   task automatic wr_serve(input logic who, input logic [31:0] addr, input logic [4:0] len,
                           input logic tog, output int gap);
      int   n;
      int   guard;
      logic rdy;
      gap = 0;
      @(negedge clk);
      set_wr_beat(1'b0, 1'b0, '0, 1'b0);
      set_wr_beat(1'b1, 1'b0, '0, 1'b0);
      mem_wr_ready = 0; mem_wr_req_ready = 1;
      #1;
      while (!mem_wr_req_valid && gap < 20) begin
         @(negedge clk); #1; gap++;
      end
      chk("wr_grant_seen", 32'(gap < 20), 32'd1);
      chk("wr_owner", 32'(wr_owner), 32'(who));
      chk("wr_req_addr", mem_wr_req_addr, addr);
      chk("wr_req_len", 32'(mem_wr_req_len), 32'(len));
      chk("wr_req_ready_own", 32'(wr_req_ready_of(who)), 32'd1);
      chk("wr_req_ready_other", 32'(wr_req_ready_of(!who)), 32'd0);
      @(posedge clk); #1;
      set_wr_req(who, 1'b0, addr, len);
      mem_wr_req_ready = 0;
      n = 0; guard = 0; rdy = 1'b0;
      while (n <= int'(len) && guard < 300) begin
         @(negedge clk);
         set_wr_beat(who, 1'b1, addr ^ 32'(n), n == int'(len));
         rdy = tog ? ~rdy : 1'b1;
         mem_wr_ready = rdy;
         #1;
         chk("mem_wr_valid", 32'(mem_wr_valid), 32'd1);
         chk("mem_wr_data", mem_wr_data, addr ^ 32'(n));
         chk("mem_wr_last", 32'(mem_wr_last), 32'(n == int'(len)));
         chk("wr_ready_own", 32'(wr_ready_of(who)), 32'(rdy));
         chk("wr_ready_other", 32'(wr_ready_of(!who)), 32'd0);
         if (rdy) n++;
         guard++;
      end
      chk("wr_beats", 32'(n), 32'(len) + 32'd1);
   endtask

   typedef struct {
      logic       req0;
      logic       req1;
      logic [4:0] len;
      int         nb;
      logic       exp_first;
      logic       exp_err;
   } rd_vec_t;

   rd_vec_t tbl[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          gap;
      logic [31:0] a0, a1;
      logic        first;
      logic        rd_prio_m, wr_prio_m, err_m, win;
      logic [1:0]  mask;
      logic [4:0]  len0, len1, lw;
      int          nb;

      rst = 1'b1;
      clear_inputs();

      // req0 req1 len nb first err
      tbl[0] = '{1'b0, 1'b1, 5'd7,  8,  1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 5'd3,  4,  1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 5'd0,  1,  1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 5'd7,  4,  1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 5'd2,  4,  1'b0, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 5'd31, 32, 1'b0, 1'b0};

      for (int i = 0; i < 6; i++) begin
         do_reset();
         a0 = 32'h2000 + 32'(i * 256);
         a1 = 32'h1000 + 32'(i * 256);
         if (tbl[i].req0) set_rd_req(1'b0, 1'b1, a0, tbl[i].len);
         if (tbl[i].req1) set_rd_req(1'b1, 1'b1, a1, tbl[i].len);
         first = tbl[i].exp_first;
         rd_serve(first, first ? a1 : a0, tbl[i].len, tbl[i].nb, 1'b0, gap);
         chk("rd_first_gap", 32'(gap), 32'd0);
         if (tbl[i].req0 && tbl[i].req1) begin
            rd_serve(!first, first ? a0 : a1, tbl[i].len, tbl[i].nb, 1'b0, gap);
            chk("rd_second_gap", 32'(gap), 32'd1);
         end
         @(negedge clk); #1;
         chk("rd_tbl_err", 32'(beat_err), 32'(tbl[i].exp_err));
         chk("rd_tbl_idle", 32'(mem_rd_req_valid), 32'd0);
         chk("rd_tbl_owner", 32'(rd_owner), 32'((tbl[i].req0 && tbl[i].req1) ? !first : first));
      end

      // Early last sets beat_err, which survives a clean burst until reset
      do_reset();
      set_rd_req(1'b1, 1'b1, 32'h3000, 5'd7);
      rd_serve(1'b1, 32'h3000, 5'd7, 4, 1'b0, gap);
      @(negedge clk); #1;
      chk("err_set", 32'(beat_err), 32'd1);
      set_rd_req(1'b0, 1'b1, 32'h3100, 5'd1);
      rd_serve(1'b0, 32'h3100, 5'd1, 2, 1'b0, gap);
      @(negedge clk); #1;
      chk("err_sticky", 32'(beat_err), 32'd1);
      do_reset();

      // Reset during beat 3 of a read: memory keeps pushing, nothing gets through
      set_rd_req(1'b0, 1'b1, 32'h4000, 5'd7);
      @(negedge clk);
      mem_rd_req_ready = 1;
      #1;
      chk("mid_rst_req", 32'(mem_rd_req_valid), 32'd1);
      @(posedge clk); #1;
      set_rd_req(1'b0, 1'b0, 32'h4000, 5'd7);
      mem_rd_req_ready = 0;
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_rd_valid = 1; mem_rd_rdata = 32'h4000 + 32'(b); mem_rd_last = 0; m0_rd_ready = 1;
      end
      @(negedge clk);
      mem_rd_rdata = 32'h4002;
      rst = 1'b1;
      #1;
      chk("mid_rst_beat3", 32'(m0_rd_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_quiet", 32'(hs_outputs()), 32'd0);
      chk("mid_rst_owner", 32'(rd_owner), 32'd0);
      set_rd_req(1'b1, 1'b1, 32'h5000, 5'd3);
      rd_serve(1'b1, 32'h5000, 5'd3, 4, 1'b0, gap);
      chk("mid_rst_regrant_gap", 32'(gap), 32'd0);

      // M1 streams writes while M0 keeps asking: grants alternate M1,M0,M1,M0
      do_reset();
      set_wr_req(1'b1, 1'b1, 32'h6000, 5'd3);
      @(negedge clk);
      set_wr_req(1'b0, 1'b1, 32'h7000, 5'd2);
      wr_serve(1'b1, 32'h6000, 5'd3, 1'b0, gap);
      set_wr_req(1'b1, 1'b1, 32'h6100, 5'd3);
      wr_serve(1'b0, 32'h7000, 5'd2, 1'b0, gap);
      chk("wr_alt_gap1", 32'(gap), 32'd1);
      set_wr_req(1'b0, 1'b1, 32'h7100, 5'd2);
      wr_serve(1'b1, 32'h6100, 5'd3, 1'b0, gap);
      chk("wr_alt_gap2", 32'(gap), 32'd1);
      wr_serve(1'b0, 32'h7100, 5'd2, 1'b0, gap);
      chk("wr_alt_gap3", 32'(gap), 32'd1);

      // Write len=7 with mem_wr_ready toggling each cycle
      do_reset();
      set_wr_req(1'b1, 1'b1, 32'h8000, 5'd7);
      wr_serve(1'b1, 32'h8000, 5'd7, 1'b1, gap);
      @(negedge clk);
      set_wr_beat(1'b1, 1'b0, '0, 1'b0);
      #1;
      chk("wr_tog_done", 32'(mem_wr_valid), 32'd0);
      chk("wr_tog_err", 32'(beat_err), 32'd0);

      // Randomized traffic: expected winners follow "favour whoever did not
      // win last time on this channel"; beat_err is set by any burst whose
      // last does not land on beat len+1
      do_reset();
      rd_prio_m = 1'b0; wr_prio_m = 1'b0; err_m = 1'b0;
      for (int k = 0; k < 40; k++) begin
         mask = 2'($urandom_range(1, 3));
         len0 = 5'($urandom_range(0, 9));
         len1 = 5'($urandom_range(0, 9));
         a0   = $urandom & 32'hFFFF_FF00;
         a1   = $urandom & 32'hFFFF_FF00;
         if ($urandom_range(0, 1) == 0) begin
            if (mask[0]) set_rd_req(1'b0, 1'b1, a0, len0);
            if (mask[1]) set_rd_req(1'b1, 1'b1, a1, len1);
            win = (mask == 2'b11) ? rd_prio_m : mask[1];
            for (int g = 0; g < 2; g++) begin
               if (g == 0 || mask == 2'b11) begin
                  lw = win ? len1 : len0;
                  nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 32'(lw) + 2))
                                                   : int'(lw) + 1;
                  if (nb != int'(lw) + 1) err_m = 1'b1;
                  rd_serve(win, win ? a1 : a0, lw, nb, 1'b1, gap);
                  if (g == 1) chk("rnd_rd_gap", 32'(gap), 32'd1);
                  rd_prio_m = !win;
                  win = !win;
               end
            end
         end else begin
            if (mask[0]) set_wr_req(1'b0, 1'b1, a0, len0);
            if (mask[1]) set_wr_req(1'b1, 1'b1, a1, len1);
            win = (mask == 2'b11) ? wr_prio_m : mask[1];
            for (int g = 0; g < 2; g++) begin
               if (g == 0 || mask == 2'b11) begin
                  lw = win ? len1 : len0;
                  wr_serve(win, win ? a1 : a0, lw, 1'($urandom_range(0, 1)), gap);
                  if (g == 1) chk("rnd_wr_gap", 32'(gap), 32'd1);
                  wr_prio_m = !win;
                  win = !win;
               end
            end
         end
         @(negedge clk);
         set_wr_beat(1'b0, 1'b0, '0, 1'b0);
         set_wr_beat(1'b1, 1'b0, '0, 1'b0);
         mem_rd_valid = 0; mem_rd_last = 0;
         #1;
         chk("rnd_beat_err", 32'(beat_err), 32'(err_m));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, data beat width of all rdata/wdata ports.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset; every flop SHALL change only on posedge clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 m{0,1}_rd_req_addr / m{0,1}_rd_req_len  input  32 / 5  read burst address and length (beats-1) per master; M0 = CPU, M1 = DMA engine.
REQ-006 m{0,1}_rd_req_valid  input  1  read request; m{0,1}_rd_req_ready  output  1  read request accepted.
REQ-007 m{0,1}_rd_rdata / m{0,1}_rd_last / m{0,1}_rd_valid  output  DATA_WIDTH / 1 / 1  routed read beat; m{0,1}_rd_ready  input  1.
REQ-008 m{0,1}_wr_req_addr / m{0,1}_wr_req_len / m{0,1}_wr_req_valid  input  32 / 5 / 1; m{0,1}_wr_req_ready  output  1.
REQ-009 m{0,1}_wr_data / m{0,1}_wr_valid / m{0,1}_wr_last  input  DATA_WIDTH / 1 / 1; m{0,1}_wr_ready  output  1.
REQ-010 mem_rd_req_{addr,len,valid}  output  32/5/1; mem_rd_req_ready  input  1; mem_rd_{rdata,last,valid}  input  DATA_WIDTH/1/1; mem_rd_ready  output  1.
REQ-011 mem_wr_req_{addr,len,valid}  output  32/5/1; mem_wr_req_ready  input  1; mem_wr_{data,valid,last}  output  DATA_WIDTH/1/1; mem_wr_ready  input  1.
REQ-012 rd_owner / wr_owner  output  1  current or last grant holder (0 = M0, 1 = M1); beat_err  output  1  sticky burst-length mismatch flag.

Function
REQ-013 Read and write channels SHALL be arbitrated independently, each by a three-state FSM: IDLE, REQ, DATA.
REQ-014 In IDLE, if any m*_req_valid is high, the FSM SHALL latch the owner and move to REQ next cycle. With both valid, the master that did not win the previous grant on that channel wins; after reset, M0 wins.
REQ-015 In REQ, mem_*_req_{addr,len,valid} SHALL equal the owner's request fields; the owner's req_ready SHALL equal mem_*_req_ready.
REQ-016 REQ SHALL go to DATA on the cycle with mem_*_req_valid && mem_*_req_ready; the granted len SHALL be latched then.
REQ-017 In DATA (read), owner rd_{rdata,last,valid} SHALL mirror mem_rd_*, and mem_rd_ready SHALL equal the owner's rd_ready.
REQ-018 In DATA (write), mem_wr_{data,valid,last} SHALL mirror the owner, and the owner's wr_ready SHALL equal mem_wr_ready.
REQ-019 Outside its own grant, a master SHALL see all req_ready, ready and valid outputs at 0. mem_*_req_valid, mem_rd_ready and mem_wr_valid SHALL be 0 outside REQ/DATA.
REQ-020 A 5-bit beat counter per channel SHALL clear on entering DATA and increment on each accepted beat (valid && ready).
REQ-021 The DATA-to-IDLE transition SHALL occur on an accepted beat with last=1. The priority pointer SHALL flip to favour the non-owner.
REQ-022 beat_err SHALL set if last=1 arrives with counter != latched len, or if counter == len is accepted without last. The transfer SHALL still terminate only on last.
REQ-023 A new request SHALL NOT be granted in the same cycle a burst completes; minimum request-to-request gap is 1 IDLE cycle.
REQ-024 A request withdrawn while in REQ is illegal. The arbiter SHALL hold the grant until the handshake completes.

Reset
REQ-025 On rst, both FSMs SHALL enter IDLE, priority SHALL favour M0, and rd_owner, wr_owner, beat_err and beat counters SHALL be 0. All valid/ready outputs SHALL be 0 in the following cycle.
REQ-026 A rst asserted mid-burst SHALL abort the transfer without flushing; beats still returned by memory SHALL be dropped, since mem_rd_ready is 0.

Structure
REQ-027 Shared package: FSM state encoding (IDLE/REQ/DATA, one-hot, 3 bits) and owner constants M_CPU=0, M_DMA=1.
REQ-028 One sub-module, arb_channel, SHALL hold the FSM, priority pointer and beat counter; it SHALL be instantiated twice, once for read and once for write. Muxing SHALL stay in the top.

Verification
REQ-029 M1 alone, read len=7 at 0x1000 with 8 beats -> mem_rd_req_addr=0x1000, 8 beats on M1 with m1_rd_last on beat 8, rd_owner=1, back to IDLE.
REQ-030 M0 and M1 raise rd_req_valid in the same cycle after reset -> M0 granted first; M1 granted 1 cycle after M0's last beat.
REQ-031 M1 streams back-to-back write bursts while M0 requests -> grants alternate M1, M0, M1; no master starves.
REQ-032 Write len=7 with mem_wr_ready toggling every cycle -> exactly 8 beats forwarded, wr_last on the 8th, non-owner m0_wr_ready=0 throughout.
REQ-033 Read len=7, memory asserts last on beat 4 -> beat_err=1, FSM returns to IDLE, beat_err stays 1 until rst.
REQ-034 rst pulsed during beat 3 of a read -> next cycle FSM=IDLE, all handshake outputs 0, new request served normally.
